countdown_timer: RTL and testbench



---
 rtl/countdown_timer.sv | 95 +++++++++
 tb/tb_countdown_timer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: BCD mm:ss countdown with clamped preset load, pause/resume,
// a sticky done level and a one-cycle alarm on expiry.
module countdown_timer #(
    parameter logic [7:0] MAX_MIN = 8'h99
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       second,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       alarm
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] min_q, min_d, sec_q, sec_d;
    logic       running_q, done_q, alarm_q, alarm_d;
    logic [3:0] min_tens_c, min_ones_c;
    logic [7:0] min_clamp, sec_clamp, min_dec, sec_dec;
    logic       s_borrow, t_borrow, m_borrow;

    assign min_tens_c = (load_min[7:4] > 4'd9) ? 4'd9 : load_min[7:4];
    assign min_ones_c = (load_min[3:0] > 4'd9) ? 4'd9 : load_min[3:0];
    assign min_clamp  = ({min_tens_c, min_ones_c} > MAX_MIN) ? MAX_MIN : {min_tens_c, min_ones_c};
    assign sec_clamp  = (load_sec[7:4] > 4'd5 || load_sec[3:0] > 4'd9) ? 8'h59 : load_sec;

    // Borrow ripples seconds ones -> seconds tens -> minutes ones -> minutes tens
    assign s_borrow = sec_q[3:0] == 4'd0;
    assign t_borrow = s_borrow && sec_q[7:4] == 4'd0;
    assign m_borrow = t_borrow && min_q[3:0] == 4'd0;
    assign sec_dec  = {s_borrow ? ((sec_q[7:4] == 4'd0) ? 4'd5 : sec_q[7:4] - 4'd1) : sec_q[7:4],
                       s_borrow ? 4'd9 : sec_q[3:0] - 4'd1};
    assign min_dec  = {m_borrow ? min_q[7:4] - 4'd1 : min_q[7:4],
                       t_borrow ? ((min_q[3:0] == 4'd0) ? 4'd9 : min_q[3:0] - 4'd1) : min_q[3:0]};

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        alarm_d = 1'b0;
        if (load) begin
            state_d = IDLE;
            min_d   = min_clamp;
            sec_d   = sec_clamp;
        end else begin
            case (state_q)
                IDLE:    if (start && {min_q, sec_q} != 16'h0000) state_d = RUN;
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (second) begin
                        min_d = min_dec;
                        sec_d = sec_dec;
                        if ({min_dec, sec_dec} == 16'h0000) begin
                            state_d = DONE;
                            alarm_d = 1'b1;
                        end
                    end
                end
                PAUSE:   if (start && !stop) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q   <= IDLE;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            running_q <= state_d == RUN;
            done_q    <= state_d == DONE;
            alarm_q   <= alarm_d;
        end
    end

    assign min_bcd = min_q;
    assign sec_bcd = sec_q;
    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus against a total-seconds reference model,
// compared every cycle, plus hand-computed literal checkpoints.
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       second = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [7:0] load_min = 8'h00, load_sec = 8'h00;
    logic [7:0] min_bcd, sec_bcd;
    logic       running, done, alarm;
    int         checks = 0, errors = 0;
    logic       chk_en = 1'b0;
    int         m_total = 0, m_mode = 0;
    logic       m_alarm = 1'b0;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    countdown_timer dut (
        .clk(clk), .clear(clear), .second(second), .load(load),
        .load_min(load_min), .load_sec(load_sec), .start(start), .stop(stop),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    function automatic int clamp_total(input logic [7:0] lm, input logic [7:0] ls);
        int mt, mo, st, so, m, s;
        mt = (int'(lm[7:4]) > 9) ? 9 : int'(lm[7:4]);
        mo = (int'(lm[3:0]) > 9) ? 9 : int'(lm[3:0]);
        m  = mt * 10 + mo;
        if (m > 99) m = 99;
        st = int'(ls[7:4]);
        so = int'(ls[3:0]);
        s  = (st > 5 || so > 9) ? 59 : st * 10 + so;
        return m * 60 + s;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    always @(posedge clk or posedge clear) begin
        if (clear) begin
            m_total <= 0;
            m_mode  <= M_IDLE;
            m_alarm <= 1'b0;
        end else begin
            m_alarm <= 1'b0;
            if (load) begin
                m_total <= clamp_total(load_min, load_sec);
                m_mode  <= M_IDLE;
            end else if (m_mode == M_RUN && stop) begin
                m_mode <= M_PAUSE;
            end else if (m_mode == M_IDLE && start && m_total != 0) begin
                m_mode <= M_RUN;
            end else if (m_mode == M_PAUSE && start && !stop) begin
                m_mode <= M_RUN;
            end else if (m_mode == M_RUN && second) begin
                m_total <= m_total - 1;
                if (m_total == 1) begin
                    m_mode  <= M_DONE;
                    m_alarm <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_min", min_bcd, to_bcd(m_total / 60));
            chk("model_sec", sec_bcd, to_bcd(m_total % 60));
            chk("model_running", {7'd0, running}, {7'd0, m_mode == M_RUN});
            chk("model_done", {7'd0, done}, {7'd0, m_mode == M_DONE});
            chk("model_alarm", {7'd0, alarm}, {7'd0, m_alarm});
        end
    end

    // Applies inputs for exactly one sampling edge; returns 2 time units after it.
    task automatic cyc(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                       input logic st, input logic sp, input logic sc);
        load = ld; load_min = lm; load_sec = ls; start = st; stop = sp; second = sc;
        @(posedge clk);
        #2;
        load = 1'b0; start = 1'b0; stop = 1'b0; second = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] lm, input logic [7:0] ls);
        cyc(1'b1, lm, ls, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic lit(input string name, input logic [7:0] m, input logic [7:0] s,
                       input logic r, input logic d);
        chk({name, "_min"}, min_bcd, m);
        chk({name, "_sec"}, sec_bcd, s);
        chk({name, "_running"}, {7'd0, running}, {7'd0, r});
        chk({name, "_done"}, {7'd0, done}, {7'd0, d});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 clear = 1'b0;
        chk_en = 1'b1;
        lit("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        chk("reset_alarm", {7'd0, alarm}, 8'h00);

        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(3);
        lit("zero_start", 8'h00, 8'h00, 1'b0, 1'b0);

        do_load(8'h01, 8'h00); cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0); tick(1);
        lit("borrow_min", 8'h00, 8'h59, 1'b1, 1'b0);
        do_load(8'h10, 8'h00); cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0); tick(1);
        lit("borrow_tens", 8'h09, 8'h59, 1'b1, 1'b0);
        do_load(8'h00, 8'h10); cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0); tick(1);
        lit("borrow_sec", 8'h00, 8'h09, 1'b1, 1'b0);

        do_load(8'h00, 8'h02); cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0); tick(1);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        lit("expiry", 8'h00, 8'h00, 1'b0, 1'b1);
        chk("expiry_alarm", {7'd0, alarm}, 8'h01);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("expiry_alarm_drop", {7'd0, alarm}, 8'h00);
        tick(5);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        lit("done_hold", 8'h00, 8'h00, 1'b0, 1'b1);

        do_load(8'h00, 8'h20); cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0); tick(3);
        lit("run3", 8'h00, 8'h17, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        tick(4);
        lit("paused", 8'h00, 8'h17, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        lit("resume_tick_ignored", 8'h00, 8'h17, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        tick(1);
        lit("resumed", 8'h00, 8'h15, 1'b1, 1'b0);

        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        lit("start_stop", 8'h00, 8'h15, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 8'h30, 1'b0, 1'b0, 1'b1);
        lit("load_over_tick", 8'h00, 8'h30, 1'b0, 1'b0);
        do_load(8'hA3, 8'h7A);
        lit("clamp", 8'h93, 8'h59, 1'b0, 1'b0);
        do_load(8'h4F, 8'h5C);
        lit("clamp_ones", 8'h49, 8'h59, 1'b0, 1'b0);

        do_load(8'h10, 8'h30); cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0); tick(3);
        lit("pre_clear", 8'h10, 8'h27, 1'b1, 1'b0);
        #1 clear = 1'b1;
        #1;
        lit("async_clear", 8'h00, 8'h00, 1'b0, 1'b0);
        chk("async_clear_alarm", {7'd0, alarm}, 8'h00);
        @(posedge clk);
        #2 clear = 1'b0;
        tick(2);
        lit("after_clear", 8'h00, 8'h00, 1'b0, 1'b0);

        @(posedge clk);
        #2 chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
